// File: rtl/cp0_param_pkg.sv
// Shared CP0 definitions: register numbers, exception codes and TLB entry field widths.
package cp0_param_pkg;

   localparam logic [4:0] CP0_INDEX    = 5'd0;
   localparam logic [4:0] CP0_RANDOM   = 5'd1;
   localparam logic [4:0] CP0_ENTRYLO0 = 5'd2;
   localparam logic [4:0] CP0_ENTRYLO1 = 5'd3;
   localparam logic [4:0] CP0_CONTEXT  = 5'd4;
   localparam logic [4:0] CP0_WIRED    = 5'd6;
   localparam logic [4:0] CP0_BADVADDR = 5'd8;
   localparam logic [4:0] CP0_COUNT    = 5'd9;
   localparam logic [4:0] CP0_ENTRYHI  = 5'd10;
   localparam logic [4:0] CP0_COMPARE  = 5'd11;
   localparam logic [4:0] CP0_STATUS   = 5'd12;
   localparam logic [4:0] CP0_CAUSE    = 5'd13;
   localparam logic [4:0] CP0_EPC      = 5'd14;
   localparam logic [4:0] CP0_CONFIG   = 5'd16;

   localparam logic [2:0] SEL0 = 3'd0;
   localparam logic [2:0] SEL1 = 3'd1;

   localparam logic [4:0] EXC_MOD  = 5'd1;
   localparam logic [4:0] EXC_TLBL = 5'd2;
   localparam logic [4:0] EXC_TLBS = 5'd3;
   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_ADES = 5'd5;

   localparam int VPN2_W  = 19;
   localparam int ASID_W  = 8;
   localparam int PFN_W   = 20;
   localparam int CATTR_W = 3;
   localparam int LO_W    = PFN_W + CATTR_W + 3;

   // Address-class exceptions are the only ones that capture the faulting address.
   function automatic logic loads_badvaddr(input logic [4:0] code);
      logic hit;
      hit = 1'b0;
      case (code)
         EXC_MOD, EXC_TLBL, EXC_TLBS, EXC_ADEL, EXC_ADES: hit = 1'b1;
         default: hit = 1'b0;
      endcase
      return hit;
   endfunction

endpackage

// File: rtl/cp0_timer.sv
// CP0 timer: Count prescaler, Count, Compare and the timer-interrupt flag TI.
module cp0_timer #(
   parameter int COUNT_DIV = 2
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        count_we,
   input  logic        compare_we,
   input  logic [31:0] wdata,
   output logic [31:0] count,
   output logic [31:0] compare,
   output logic        ti
);

   localparam logic [3:0] PRESC_TOP = 4'(COUNT_DIV - 1);

   logic [3:0] presc;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         presc   <= 4'd0;
         count   <= 32'd0;
         compare <= 32'hFFFF_FFFF;
         ti      <= 1'b0;
      end else begin
         if (count_we) begin
            count <= wdata;
            presc <= 4'd0;
         end else if (presc == PRESC_TOP) begin
            count <= count + 32'd1;
            presc <= 4'd0;
         end else begin
            presc <= presc + 4'd1;
         end

         if (compare_we) compare <= wdata;

         // Writing Compare acknowledges the interrupt even on a matching cycle.
         if (compare_we)              ti <= 1'b0;
         else if (count == compare)   ti <= 1'b1;
      end
   end

endmodule

// File: rtl/cp0_param.sv
// MIPS-style CP0 register file with TLB support registers, exception capture and timer.
module cp0_param
   import cp0_param_pkg::*;
#(
   parameter int TLBNUM    = 16,
   parameter int COUNT_DIV = 2,
   localparam int IDX_W    = $clog2(TLBNUM)
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               wb_ex,
   input  logic               wb_ex_tlb,
   input  logic               wb_bd,
   input  logic               eret_flush,
   input  logic [4:0]         wb_exccode,
   input  logic [31:0]        wb_pc,
   input  logic [31:0]        wb_badvaddr,
   input  logic               mtc0_we,
   input  logic [4:0]         addr,
   input  logic [2:0]         sel,
   input  logic [31:0]        wdata,
   input  logic [5:0]         ext_int_in,
   input  logic               tlbp,
   input  logic               tlbp_found,
   input  logic [IDX_W-1:0]   tlbp_index,
   input  logic               tlbr,
   input  logic [VPN2_W-1:0]  r_vpn2,
   input  logic [ASID_W-1:0]  r_asid,
   input  logic               r_g,
   input  logic [PFN_W-1:0]   r_pfn0,
   input  logic [CATTR_W-1:0] r_c0,
   input  logic               r_d0,
   input  logic               r_v0,
   input  logic [PFN_W-1:0]   r_pfn1,
   input  logic [CATTR_W-1:0] r_c1,
   input  logic               r_d1,
   input  logic               r_v1,
   output logic [31:0]        rdata,
   output logic               has_int,
   output logic [31:0]        cp0_epc,
   output logic [31:0]        cp0_entryhi,
   output logic [31:0]        cp0_entrylo0,
   output logic [31:0]        cp0_entrylo1,
   output logic [31:0]        cp0_index,
   output logic [IDX_W-1:0]   cp0_random
);

   localparam logic [IDX_W-1:0] RAND_TOP = IDX_W'(TLBNUM - 1);

   logic               exl, ie;
   logic [7:0]         im;
   logic               bd;
   logic [4:0]         exccode;
   logic [1:0]         ip_sw;
   logic [5:0]         ip_hw;
   logic [31:0]        epc, badvaddr;
   logic [VPN2_W-1:0]  hi_vpn2;
   logic [ASID_W-1:0]  hi_asid;
   logic [8:0]         ctx_ptebase;
   logic [VPN2_W-1:0]  ctx_badvpn2;
   logic [LO_W-1:0]    lo0, lo1;
   logic               idx_p;
   logic [IDX_W-1:0]   idx, wired, random;
   logic [2:0]         k0;
   logic [31:0]        count, compare;
   logic               ti;
   logic [7:0]         ip;

   logic we_index, we_lo0, we_lo1, we_context, we_wired, we_count, we_entryhi;
   logic we_compare, we_status, we_cause, we_epc, we_config;

   assign we_index   = mtc0_we && sel == SEL0 && addr == CP0_INDEX;
   assign we_lo0     = mtc0_we && sel == SEL0 && addr == CP0_ENTRYLO0;
   assign we_lo1     = mtc0_we && sel == SEL0 && addr == CP0_ENTRYLO1;
   assign we_context = mtc0_we && sel == SEL0 && addr == CP0_CONTEXT;
   assign we_wired   = mtc0_we && sel == SEL0 && addr == CP0_WIRED;
   assign we_count   = mtc0_we && sel == SEL0 && addr == CP0_COUNT;
   assign we_entryhi = mtc0_we && sel == SEL0 && addr == CP0_ENTRYHI;
   assign we_compare = mtc0_we && sel == SEL0 && addr == CP0_COMPARE;
   assign we_status  = mtc0_we && sel == SEL0 && addr == CP0_STATUS;
   assign we_cause   = mtc0_we && sel == SEL0 && addr == CP0_CAUSE;
   assign we_epc     = mtc0_we && sel == SEL0 && addr == CP0_EPC;
   assign we_config  = mtc0_we && sel == SEL0 && addr == CP0_CONFIG;

   cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
      .clk        (clk),
      .resetn     (resetn),
      .count_we   (we_count),
      .compare_we (we_compare),
      .wdata      (wdata),
      .count      (count),
      .compare    (compare),
      .ti         (ti)
   );

   always_ff @(posedge clk) begin
      if (!resetn) begin
         exl         <= 1'b0;
         ie          <= 1'b0;
         im          <= 8'd0;
         bd          <= 1'b0;
         exccode     <= 5'd0;
         ip_sw       <= 2'd0;
         ip_hw       <= 6'd0;
         epc         <= 32'd0;
         badvaddr    <= 32'd0;
         hi_vpn2     <= '0;
         hi_asid     <= '0;
         ctx_ptebase <= 9'd0;
         ctx_badvpn2 <= '0;
         lo0         <= '0;
         lo1         <= '0;
         idx_p       <= 1'b0;
         idx         <= '0;
         wired       <= '0;
         random      <= RAND_TOP;
         k0          <= 3'd3;
      end else begin
         if (wb_ex)           exl <= 1'b1;
         else if (eret_flush) exl <= 1'b0;
         else if (we_status)  exl <= wdata[1];
         if (we_status) begin
            im <= wdata[15:8];
            ie <= wdata[0];
         end

         // A nested exception keeps the original BD and EPC so ERET returns to the first fault.
         if (wb_ex) begin
            exccode <= wb_exccode;
            if (!exl) bd <= wb_bd;
         end
         if (we_cause) ip_sw <= wdata[9:8];
         ip_hw <= ext_int_in;

         if (wb_ex) begin
            if (!exl) epc <= wb_bd ? wb_pc - 32'd4 : wb_pc;
         end else if (we_epc) begin
            epc <= wdata;
         end
         if (wb_ex && loads_badvaddr(wb_exccode)) badvaddr <= wb_badvaddr;

         if (wb_ex_tlb)       hi_vpn2 <= wb_badvaddr[31:13];
         else if (we_entryhi) hi_vpn2 <= wdata[31:13];
         else if (tlbr)       hi_vpn2 <= r_vpn2;
         if (we_entryhi)      hi_asid <= wdata[7:0];
         else if (tlbr)       hi_asid <= r_asid;

         if (wb_ex_tlb)  ctx_badvpn2 <= wb_badvaddr[31:13];
         if (we_context) ctx_ptebase <= wdata[31:23];

         if (we_lo0)    lo0 <= wdata[LO_W-1:0];
         else if (tlbr) lo0 <= {r_pfn0, r_c0, r_d0, r_v0, r_g};
         if (we_lo1)    lo1 <= wdata[LO_W-1:0];
         else if (tlbr) lo1 <= {r_pfn1, r_c1, r_d1, r_v1, r_g};

         // P is owned by tlbp; software may only rewrite the index field.
         if (tlbp) idx_p <= !tlbp_found;
         if (we_index)                idx <= wdata[IDX_W-1:0];
         else if (tlbp && tlbp_found) idx <= tlbp_index;

         if (we_wired) begin
            wired  <= wdata[IDX_W-1:0];
            random <= RAND_TOP;
         end else if (random <= wired) begin
            random <= RAND_TOP;
         end else begin
            random <= random - 1'b1;
         end

         if (we_config) k0 <= wdata[2:0];
      end
   end

   assign ip = {ip_hw[5] | ti, ip_hw[4:0], ip_sw};

   logic [31:0] status_img, cause_img, context_img;

   assign status_img   = {9'd0, 1'b1, 6'd0, im, 6'd0, exl, ie};
   assign cause_img    = {bd, ti, 14'd0, ip, 1'b0, exccode, 2'b00};
   assign context_img  = {ctx_ptebase, ctx_badvpn2, 4'd0};
   assign cp0_epc      = epc;
   assign cp0_entryhi  = {hi_vpn2, 5'd0, hi_asid};
   assign cp0_entrylo0 = {6'd0, lo0};
   assign cp0_entrylo1 = {6'd0, lo1};
   assign cp0_index    = {idx_p, {(31 - IDX_W){1'b0}}, idx};
   assign cp0_random   = random;

   assign has_int = (|(ip & im)) & ie & !exl;

   always_comb begin
      rdata = 32'd0;
      if (sel == SEL0) begin
         case (addr)
            CP0_INDEX:    rdata = cp0_index;
            CP0_RANDOM:   rdata = {{(32 - IDX_W){1'b0}}, random};
            CP0_ENTRYLO0: rdata = cp0_entrylo0;
            CP0_ENTRYLO1: rdata = cp0_entrylo1;
            CP0_CONTEXT:  rdata = context_img;
            CP0_WIRED:    rdata = {{(32 - IDX_W){1'b0}}, wired};
            CP0_BADVADDR: rdata = badvaddr;
            CP0_COUNT:    rdata = count;
            CP0_ENTRYHI:  rdata = cp0_entryhi;
            CP0_COMPARE:  rdata = compare;
            CP0_STATUS:   rdata = status_img;
            CP0_CAUSE:    rdata = cause_img;
            CP0_EPC:      rdata = epc;
            CP0_CONFIG:   rdata = {1'b1, 28'd0, k0};
            default:      rdata = 32'd0;
         endcase
      end else if (sel == SEL1 && addr == CP0_CONFIG) begin
         rdata = {1'b0, 6'(TLBNUM - 1), 25'd0};
      end
   end

endmodule

// File: doc/cp0_param.md
CP0_PARAM -- requirements
Module: cp0_param

Interface
REQ-001 Parameter TLBNUM, default 16, TLB entry count; power of two, 8..64; IDX_W = log2(TLBNUM).
REQ-002 Parameter COUNT_DIV, default 2, clk cycles per Count increment; range 1..16.
REQ-003 Ports:
- clk  in  1  clock; one clock domain; all state updates on posedge clk.
- resetn  in  1  reset, synchronous, active-low.
- wb_ex / wb_ex_tlb / wb_bd / eret_flush  in  1 each  WB exception, TLB-class exception, delay-slot flag, ERET commit.
- wb_exccode  in  5  exception code.
- wb_pc / wb_badvaddr  in  32 each  faulting PC, faulting address.
- mtc0_we  in  1  CP0 write strobe.
- addr / sel  in  5 / 3  register number and select; shared by read and write.
- wdata  in  32  write data.
- ext_int_in  in  6  level hardware interrupts.
- tlbp / tlbp_found  in  1 each  probe commit, probe hit.
- tlbp_index  in  IDX_W  probe hit index.
- tlbr  in  1  TLB read commit.
- r_vpn2 19, r_asid 8, r_g 1, r_pfn0/r_pfn1 20, r_c0/r_c1 3, r_d0/r_d1/r_v0/r_v1 1  in  TLB read entry.
- rdata  out  32  combinational read of (addr,sel); 0 for unimplemented registers.
- has_int  out  1  interrupt pending.
- cp0_epc / cp0_entryhi / cp0_entrylo0 / cp0_entrylo1 / cp0_index  out  32 each  live register images.
- cp0_random  out  IDX_W  TLBWR target index.

Function
REQ-004 Registers (addr/sel): Index 0/0, Random 1/0, EntryLo0 2/0, EntryLo1 3/0, Context 4/0, Wired 6/0, BadVAddr 8/0, Count 9/0, EntryHi 10/0, Compare 11/0, Status 12/0, Cause 13/0, EPC 14/0, Config 16/0, Config1 16/1.
REQ-005 Update priority per field: wb_ex > eret_flush > mtc0_we > tlbr/tlbp; a blocked lower-priority update is dropped, not deferred.
REQ-006 rdata reflects pre-edge state; a write is visible to reads from the next cycle.
REQ-007 Status: IM[15:8], EXL[1] and IE[0] are RW; BEV[22] is read-only 1; wb_ex sets EXL; eret_flush clears EXL.
REQ-008 Cause: on wb_ex, ExcCode is loaded, and BD is loaded only when EXL=0; IP[1:0] are RW; IP[7:2] are registered each cycle from ext_int_in, with TI ORed into IP[7].
REQ-009 EPC: on wb_ex with EXL=0, EPC gets wb_pc-4 if wb_bd, else wb_pc; with EXL=1, EPC is unchanged.
REQ-010 BadVAddr: loaded from wb_badvaddr on wb_ex with exccode AdEL(4), AdES(5), Mod(1), TLBL(2) or TLBS(3); otherwise unchanged.
REQ-011 wb_ex_tlb loads EntryHi.VPN2 and Context.BadVPN2[22:4] from wb_badvaddr[31:13]; Context.PTEBase[31:23] is RW.
REQ-012 Prescaler runs 0..COUNT_DIV-1, and Count increments (wrapping at 2^32) when the prescaler equals COUNT_DIV-1; an mtc0 to Count loads Count and clears the prescaler.
REQ-013 Cause.TI is set in every cycle Count==Compare and cleared by an mtc0 to Compare; the clear wins if both occur in the same cycle.
REQ-014 Random decrements each cycle; when Random<=Wired, the next value is TLBNUM-1.
REQ-015 An mtc0 to Wired loads wdata[IDX_W-1:0] and forces Random to TLBNUM-1 in the same edge.
REQ-016 Index: tlbp miss sets P=1; tlbp hit clears P and loads tlbp_index; an mtc0 writes Index[IDX_W-1:0] only.
REQ-017 EntryLo0 and EntryLo1 are 6'b0,PFN,C,D,V,G; tlbr loads both, with G=r_g in each.
REQ-018 Config: bit31=1; K0[2:0] is RW with reset value 3; other bits are 0.
REQ-019 Config1: [30:25]=TLBNUM-1, other bits 0; read-only.
REQ-020 has_int = |(Cause.IP & Status.IM) & IE & !EXL, combinational.

Reset
REQ-021 With resetn=0 at an edge, the following are cleared: EXL, IE, IM, BD, TI, IP, ExcCode, Count, prescaler, Wired, Index, EntryHi, EntryLo0/1 and Context.
REQ-022 Reset values: Compare=32'hFFFF_FFFF; Random=TLBNUM-1; K0=3; EPC and BadVAddr=0.
REQ-023 Reset overrides every concurrent event; outputs take reset values on the cycle after the reset edge.

Structure
REQ-024 A shared package holds register-number constants, exception codes and the TLB entry field widths.
REQ-025 One sub-module, cp0_timer, contains the prescaler, Count, Compare and TI.

Verification
REQ-026 Reset, then read Random with TLBNUM=16 -> 15, 14, ... 0, 15; after mtc0 Wired=4, the sequence is 15..4, 15.
REQ-027 COUNT_DIV=3, mtc0 Count=10, Compare=12 -> Count=12 after 6 cycles; TI=1, IP[7]=1 one cycle later; with IM[7]=1, IE=1 -> has_int=1; mtc0 Compare -> TI=0.
REQ-028 wb_ex with wb_bd=1, wb_pc=0x80001004, exccode=AdEL, badvaddr=0x3 -> EPC=0x80001000, BD=1, EXL=1, BadVAddr=0x3; a second wb_ex leaves EPC unchanged.
REQ-029 wb_ex_tlb with exccode TLBL and badvaddr=0x0040_6123 -> EntryHi.VPN2=0x00203, Context[22:4]=0x00203, BadVAddr updated.
REQ-030 tlbp miss -> Index=0x8000_0000; tlbp hit index 5 -> Index=5; tlbr -> EntryLo0/1 and EntryHi equal the r_* values.
